trig_rate_monitor: RTL
======================

# trig_rate_monitor

Receiving-end checker for the DMB random/burst trigger generator: consumes the L1A stream and the six LCT lines, measures per-channel rates over a fixed gate, and flags CMS trigger-rule violations. It sits on the DMB control FPGA's test path, in parallel with the normal L1A/LCT distribution, and its results are read back over the JTAG register interface.

## Interface
- GATE_CYC, 40000: gate length in CLK cycles; 40000 at 40 MHz = 1 ms, so counts read directly in kHz.
- CNT_W, 16: width of rate and error counters.
- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- ENA  in  1  measurement enable (level).
- CLR  in  1  synchronous clear pulse.
- GTRG_IN  in  1  L1A trigger line.
- LCT_IN  in  6  LCT lines; bit 0 is the LCT-OR.
- RD_SEL  in  3  readout select: 0 = L1A, 1..6 = LCT_IN[0..5], 7 = rule-error count.
- RD_DATA  out  CNT_W  selected latched value.
- RATE_VALID  out  1  one-cycle pulse when new latched counts are available.
- RULE1_ERR  out  1  sticky: L1A spacing below minimum.
- RULE2_ERR  out  1  sticky: too many L1As in sliding window.

## Operation
- Every input is rising-edge detected with one register stage. A level held high counts once.
- Seven live counters (L1A, LCT0..5) increment on their edges and saturate at all-ones.
- FSM states:
  - IDLE: ENA=0. Timer and live counters are held at 0; latched values are retained. ENA=1 moves to GATE.
  - GATE: the timer counts 0..GATE_CYC-1. At terminal count the FSM goes to LATCH.
  - LATCH (one cycle): live values are copied to the shadow registers. Live counters reload to 0, or to 1 if that channel has an edge this cycle. Timer resets. Next state is GATE, or IDLE if ENA=0.
- ENA falling mid-gate abandons the partial gate: no latch, no RATE_VALID.
- Rule 1: two L1A edges less than RULE1_MIN=3 cycles apart (edges at t and t+1 or t+2) set RULE1_ERR.
- Rule 2: a RULE2_WIN=25-bit shift history of L1A edges. If an edge arrives while the window already holds RULE2_MAX=2 edges, RULE2_ERR is set.
- The error counter increments once per violating edge, saturating. A single edge violating both rules counts once.
- Rule checks run whenever the block is out of reset, independent of ENA.
- CLR has priority over everything. It zeros live counters, shadows, error counter, both sticky flags, the L1A history and the timer, then returns the FSM to IDLE (or GATE if ENA=1).

## Timing
- Reset values: RD_DATA=0, RATE_VALID=0, RULE1_ERR=0, RULE2_ERR=0, FSM=IDLE, all counters, shadows and history 0.
- Input to edge detect: 1 cycle. Edge to live counter update: 1 further cycle.
- Rule flags assert 2 cycles after the violating input rises.
- RATE_VALID pulses the cycle after LATCH, together with the updated shadow values.
- RD_DATA is registered: it reflects RD_SEL 1 cycle after RD_SEL changes, and reflects new shadows 1 cycle after LATCH.
- Gate period is exactly GATE_CYC cycles, LATCH cycle included. An edge in the LATCH cycle belongs to the new gate; no edge is lost or double counted.

## Structure
- Package trig_mon_pkg holds:
  - FSM state type (IDLE, GATE, LATCH);
  - RULE1_MIN=3, RULE2_WIN=25, RULE2_MAX=2;
  - RD_SEL codes.
- Sub-module trig_edge_cnt provides edge detect, saturating live counter with load-0/load-1 and clear, and the shadow register. It is instantiated 7 times.
- The top level holds the FSM, gate timer, rule checker and readout mux.

## Test plan
- Rate count: GATE_CYC=1000, ENA=1, L1A pulses every 25 cycles. Required: RD_SEL=0 reads 40 after RATE_VALID; RULE flags stay 0.
- Rule 1: L1A edges at cycles 100 and 102. Required: RULE1_ERR=1 at 104 and error count 1; RULE2_ERR=0.
- Rule 2: edges at 0, 10 and 20, then a separate sequence at 0, 10, 25.
  - 0/10/20 → RULE2_ERR=1.
  - 0/10/25 → no error.
- Saturation/boundary: CNT_W=4 with 20 LCT_IN[3] edges in one gate. Required: reads 15. An edge exactly on the LATCH cycle reads 1 in the next gate.
- Abort and clear:
  - Drop ENA mid-gate → no RATE_VALID; shadows keep their old values.
  - Pulse CLR → all reads 0 and flags 0.
  - Assert RST_N low mid-gate → outputs 0 asynchronously.

Source files
------------

// File: rtl/trig_mon_pkg.sv
// Shared types and constants for the L1A/LCT rate monitor: FSM states,
// trigger-rule limits and readout select codes.
package trig_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GATE,
        ST_LATCH
    } mon_state_t;

    localparam int RULE1_MIN = 3;   // minimum L1A spacing in cycles
    localparam int RULE2_WIN = 25;  // sliding window length, current cycle included
    localparam int RULE2_MAX = 2;   // edges allowed in the window before a new one

    // Channel index equals the readout code: 0 = L1A, 1..6 = LCT_IN[0..5].
    localparam int         NUM_CH = 7;
    localparam logic [2:0] RD_ERR = 3'd7;

endpackage

// File: rtl/trig_edge_cnt.sv
// One rate channel: rising-edge detect, saturating live counter that can be
// held at zero or reloaded at latch time, and the shadow register.
module trig_edge_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             hold_zero,
    input  logic             do_latch,
    input  logic             din,
    output logic [CNT_W-1:0] live,
    output logic [CNT_W-1:0] shadow
);

    logic             din_d_reg;
    logic             rise_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] shadow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_d_reg  <= 1'b0;
            rise_reg   <= 1'b0;
            cnt_reg    <= '0;
            shadow_reg <= '0;
        end else begin
            din_d_reg <= din;
            rise_reg  <= din & ~din_d_reg;
            if (clr) begin
                cnt_reg    <= '0;
                shadow_reg <= '0;
            end else begin
                if (do_latch)
                    shadow_reg <= cnt_reg;
                // An edge seen in the latch cycle opens the next gate's count.
                if (hold_zero)
                    cnt_reg <= '0;
                else if (do_latch)
                    cnt_reg <= {{(CNT_W-1){1'b0}}, rise_reg};
                else if (rise_reg && (cnt_reg != '1))
                    cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign live   = cnt_reg;
    assign shadow = shadow_reg;

endmodule

// File: rtl/trig_rate_monitor.sv
// L1A/LCT rate monitor: gated per-channel rate counts with shadow readout and
// sticky trigger-rule violation flags for the random/burst trigger generator.
module trig_rate_monitor
    import trig_mon_pkg::*;
#(
    parameter int GATE_CYC = 40000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clr,
    input  logic             gtrg_in,
    input  logic [5:0]       lct_in,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rate_valid,
    output logic             rule1_err,
    output logic             rule2_err
);

    localparam int               TMR_W    = $clog2(GATE_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYC - 2);
    localparam int               HIST_W   = RULE2_WIN - 1;

    mon_state_t        state_reg, state_next;
    logic [TMR_W-1:0]  timer_reg;
    logic              hold_zero, do_latch;
    logic [NUM_CH-1:0] chan_in;
    logic [CNT_W-1:0]  live_cnt   [NUM_CH];
    logic [CNT_W-1:0]  shadow_cnt [NUM_CH];

    logic              l1a_d_reg, l1a_rise_reg;
    logic [HIST_W-1:0] hist_reg;
    logic              rule1_hit, rule2_hit;
    logic [CNT_W-1:0]  err_cnt_reg;
    logic              rule1_reg, rule2_reg, rate_valid_reg;
    logic [CNT_W-1:0]  rd_data_reg, rd_next;

    assign chan_in   = {lct_in, gtrg_in};
    assign hold_zero = (state_reg == ST_IDLE);
    assign do_latch  = (state_reg == ST_LATCH);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            trig_edge_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .clr       (clr),
                .hold_zero (hold_zero),
                .do_latch  (do_latch),
                .din       (chan_in[gi]),
                .live      (live_cnt[gi]),
                .shadow    (shadow_cnt[gi])
            );
        end
    endgenerate

    // GATE spans GATE_CYC-1 cycles so that GATE plus LATCH is exactly GATE_CYC.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (ena) state_next = ST_GATE;
            ST_GATE: begin
                if (!ena)
                    state_next = ST_IDLE;
                else if (timer_reg == TMR_LAST)
                    state_next = ST_LATCH;
            end
            ST_LATCH: state_next = ena ? ST_GATE : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (clr)
            state_next = ena ? ST_GATE : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= (clr || state_reg != ST_GATE) ? '0 : timer_reg + 1'b1;
        end
    end

    // History holds the previous RULE2_WIN-1 cycles; with the current edge
    // that covers the full window.
    assign rule1_hit = l1a_rise_reg && (|hist_reg[RULE1_MIN-2:0]);
    assign rule2_hit = l1a_rise_reg && ($countones(hist_reg) >= RULE2_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l1a_d_reg    <= 1'b0;
            l1a_rise_reg <= 1'b0;
            hist_reg     <= '0;
            err_cnt_reg  <= '0;
            rule1_reg    <= 1'b0;
            rule2_reg    <= 1'b0;
        end else begin
            l1a_d_reg    <= gtrg_in;
            l1a_rise_reg <= gtrg_in & ~l1a_d_reg;
            if (clr) begin
                hist_reg    <= '0;
                err_cnt_reg <= '0;
                rule1_reg   <= 1'b0;
                rule2_reg   <= 1'b0;
            end else begin
                hist_reg <= {hist_reg[HIST_W-2:0], l1a_rise_reg};
                if (rule1_hit) rule1_reg <= 1'b1;
                if (rule2_hit) rule2_reg <= 1'b1;
                if ((rule1_hit || rule2_hit) && (err_cnt_reg != '1))
                    err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    // During LATCH the live value is what the shadow is about to hold, so the
    // read port shows new counts in the same cycle as RATE_VALID.
    always_comb begin
        rd_next = '0;
        if (rd_sel == RD_ERR)
            rd_next = err_cnt_reg;
        else if (do_latch)
            rd_next = live_cnt[rd_sel];
        else
            rd_next = shadow_cnt[rd_sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg    <= '0;
            rate_valid_reg <= 1'b0;
        end else if (clr) begin
            rd_data_reg    <= '0;
            rate_valid_reg <= 1'b0;
        end else begin
            rd_data_reg    <= rd_next;
            rate_valid_reg <= do_latch;
        end
    end

    assign rd_data    = rd_data_reg;
    assign rate_valid = rate_valid_reg;
    assign rule1_err  = rule1_reg;
    assign rule2_err  = rule2_reg;

endmodule
